// File: rtl/difftest_commit_queue_if.sv
// Commit bus from the WB stage into the difftest commit queue.
// The WB side (master) presents one retiring instruction per cycle and
// the queue (slave) answers with in_ready.
interface difftest_commit_queue_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic [31:0]     in_inst;
  logic            in_wen;
  logic [4:0]      in_rd;
  logic [XLEN-1:0] in_wdata;
  logic            in_skip;
  logic            in_ebreak;

  modport master (
    output in_valid, in_pc, in_inst, in_wen, in_rd, in_wdata, in_skip, in_ebreak,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_pc, in_inst, in_wen, in_rd, in_wdata, in_skip, in_ebreak,
    output in_ready
  );
endinterface

// File: rtl/difftest_commit_queue.sv
// Difftest commit queue: buffers retiring instructions, drains one per
// cycle into a shadow GPR file and emits a snapshot strobe per drained
// commit. An ebreak freezes the queue (sticky halt) until reset.
module difftest_commit_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  difftest_commit_queue_if.slave wb,
  output logic                   dt_valid,
  output logic [XLEN-1:0]        dt_pc,
  output logic                   dt_skip,
  output logic [32*XLEN-1:0]     dt_rf,
  output logic                   dt_halt,
  output logic [63:0]            commit_cnt
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
    logic            wen;
    logic [4:0]      rd;
    logic [XLEN-1:0] wdata;
    logic            skip;
    logic            ebreak;
  } rec_t;

  rec_t            mem_q [DEPTH];
  logic [AW:0]     wptr_q, wptr_d;
  logic [AW:0]     rptr_q, rptr_d;
  logic [XLEN-1:0] rf_q [32];
  logic [XLEN-1:0] rf_d [32];
  logic            live_q, live_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            skip_q, skip_d;
  logic            halt_q, halt_d;
  logic [63:0]     cnt_q, cnt_d;

  logic            empty_s;
  logic            full_s;
  logic            ready_s;
  logic            push_s;
  logic            pop_s;
  rec_t            head_s;
  rec_t            in_rec_s;

  // Occupancy flags, handshake and next-state of queue, shadow file and snapshot.
  always_comb begin
    empty_s  = (wptr_q == rptr_q);
    full_s   = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    // live_q keeps in_ready low until the first edge after reset release.
    ready_s  = live_q && !full_s && !halt_q;
    push_s   = wb.in_valid && ready_s;
    pop_s    = !empty_s && !halt_q;
    head_s   = mem_q[rptr_q[AW-1:0]];
    in_rec_s = '{pc: wb.in_pc, inst: wb.in_inst, wen: wb.in_wen, rd: wb.in_rd,
                 wdata: wb.in_wdata, skip: wb.in_skip, ebreak: wb.in_ebreak};

    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    rf_d    = rf_q;
    live_d  = 1'b1;
    valid_d = 1'b0;
    pc_d    = pc_q;
    skip_d  = skip_q;
    halt_d  = halt_q;
    cnt_d   = cnt_q;

    if (push_s) begin
      wptr_d = wptr_q + {{AW{1'b0}}, 1'b1};
    end else begin
      wptr_d = wptr_q;
    end

    if (pop_s) begin
      rptr_d  = rptr_q + {{AW{1'b0}}, 1'b1};
      valid_d = 1'b1;
      pc_d    = head_s.pc;
      skip_d  = head_s.skip;
      halt_d  = head_s.ebreak;
      cnt_d   = cnt_q + 64'd1;
      // x0 is hard-wired to zero, so writes to it are dropped.
      if (head_s.wen && (head_s.rd != 5'd0)) begin
        rf_d[head_s.rd] = head_s.wdata;
      end else begin
        rf_d = rf_q;
      end
    end else begin
      rptr_d = rptr_q;
    end
  end

  // Record storage; contents need no reset because the pointers gate them.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wptr_q[AW-1:0]] <= in_rec_s;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      rf_q    <= '{default: '0};
      live_q  <= 1'b0;
      valid_q <= 1'b0;
      pc_q    <= '0;
      skip_q  <= 1'b0;
      halt_q  <= 1'b0;
      cnt_q   <= 64'd0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      rf_q    <= rf_d;
      live_q  <= live_d;
      valid_q <= valid_d;
      pc_q    <= pc_d;
      skip_q  <= skip_d;
      halt_q  <= halt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign wb.in_ready  = ready_s;
  assign dt_valid     = valid_q;
  assign dt_pc        = pc_q;
  assign dt_skip      = skip_q;
  assign dt_halt      = halt_q;
  assign commit_cnt   = cnt_q;

  for (genvar i = 0; i < 32; i++) begin : g_rf
    assign dt_rf[i*XLEN +: XLEN] = rf_q[i];
  end
endmodule

// File: tb/tb_difftest_commit_queue.sv
// Directed bench for difftest_commit_queue with a queue-based reference
// model compared every cycle plus hand-computed literal expectations.
module tb_difftest_commit_queue;
  localparam int DEPTH = 4;
  localparam int XLEN  = 32;

  logic              clk;
  logic              rst;
  logic              dt_valid;
  logic [XLEN-1:0]   dt_pc;
  logic              dt_skip;
  logic [32*XLEN-1:0] dt_rf;
  logic              dt_halt;
  logic [63:0]       commit_cnt;

  difftest_commit_queue_if #(.XLEN(XLEN)) wb ();

  difftest_commit_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk        (clk),
    .rst        (rst),
    .wb         (wb),
    .dt_valid   (dt_valid),
    .dt_pc      (dt_pc),
    .dt_skip    (dt_skip),
    .dt_rf      (dt_rf),
    .dt_halt    (dt_halt),
    .commit_cnt (commit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  typedef struct {
    logic [31:0] pc;
    logic        wen;
    logic [4:0]  rd;
    logic [31:0] wdata;
    logic        skip;
    logic        ebreak;
  } mrec_t;

  // Reference model state
  mrec_t       mq[$];
  logic [31:0] m_rf [32];
  logic [63:0] m_cnt;
  logic        m_valid, m_skip, m_halt, m_live;
  logic [31:0] m_pc;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_rf(logic [32*XLEN-1:0] exp);
    total++;
    if (dt_rf !== exp) begin
      bad++;
      for (int i = 0; i < 32; i++) begin
        if (dt_rf[i*XLEN +: XLEN] !== exp[i*XLEN +: XLEN]) begin
          $display("FAIL rf reg%0d: got %0h want %0h at %0t", i,
                   dt_rf[i*XLEN +: XLEN], exp[i*XLEN +: XLEN], $time);
          break;
        end
      end
    end
  endtask

  // Model: one cycle of spec behaviour per rising edge, cleared by reset.
  always @(posedge clk or posedge rst) begin
    mrec_t h;
    mrec_t r;
    bit    rdy;
    bit    do_pop;
    bit    do_push;
    if (rst) begin
      mq.delete();
      for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
      m_cnt = 64'd0; m_valid = 1'b0; m_skip = 1'b0; m_halt = 1'b0;
      m_live = 1'b0; m_pc = 32'd0;
    end else begin
      rdy     = m_live && (mq.size() < DEPTH) && !m_halt;
      do_pop  = (mq.size() > 0) && !m_halt;
      do_push = wb.in_valid && rdy;
      r = '{pc: wb.in_pc, wen: wb.in_wen, rd: wb.in_rd, wdata: wb.in_wdata,
            skip: wb.in_skip, ebreak: wb.in_ebreak};
      m_valid = 1'b0;
      if (do_pop) begin
        h = mq.pop_front();
        if (h.wen && h.rd != 5'd0) m_rf[h.rd] = h.wdata;
        m_pc = h.pc; m_skip = h.skip; m_cnt = m_cnt + 64'd1; m_valid = 1'b1;
        if (h.ebreak) m_halt = 1'b1;
      end
      if (do_push) mq.push_back(r);
      m_live = 1'b1;
    end
  end

  // Compare DUT against the model on every falling edge.
  always @(negedge clk) begin
    logic [32*XLEN-1:0] exp_rf;
    if (cmp_en) begin
      for (int i = 0; i < 32; i++) exp_rf[i*XLEN +: XLEN] = m_rf[i];
      chk("m_valid", {63'd0, dt_valid}, {63'd0, m_valid});
      chk("m_ready", {63'd0, wb.in_ready},
          {63'd0, (m_live && mq.size() < DEPTH && !m_halt && !rst)});
      chk("m_cnt", commit_cnt, m_cnt);
      chk("m_halt", {63'd0, dt_halt}, {63'd0, m_halt});
      chk("m_pc", {32'd0, dt_pc}, {32'd0, m_pc});
      chk("m_skip", {63'd0, dt_skip}, {63'd0, m_skip});
      chk_rf(exp_rf);
    end
  end

  task automatic idle();
    wb.in_valid = 1'b0; wb.in_pc = 32'd0; wb.in_inst = 32'd0; wb.in_wen = 1'b0;
    wb.in_rd = 5'd0; wb.in_wdata = 32'd0; wb.in_skip = 1'b0; wb.in_ebreak = 1'b0;
  endtask

  task automatic set_rec(logic [31:0] pc, logic wen, logic [4:0] rd,
                         logic [31:0] wdata, logic skip, logic ebreak);
    wb.in_valid = 1'b1; wb.in_pc = pc; wb.in_wen = wen; wb.in_rd = rd;
    wb.in_wdata = wdata; wb.in_skip = skip; wb.in_ebreak = ebreak;
    wb.in_inst = ebreak ? 32'h0010_0073 : 32'h0000_0013;
  endtask

  // Present a record from a falling edge and hold it until accepted.
  task automatic push_rec(logic [31:0] pc, logic wen, logic [4:0] rd,
                          logic [31:0] wdata, logic skip, logic ebreak);
    int n;
    n = 0;
    set_rec(pc, wen, rd, wdata, skip, ebreak);
    while (!wb.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 20) begin
      bad++;
      $display("FAIL push_timeout: got ready=0 want ready=1 pc=%0h", pc);
    end
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish want finish by 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    idle();
    #3 rst = 1'b1;
    cmp_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", {63'd0, dt_valid}, 64'd0);
    chk("rst_ready", {63'd0, wb.in_ready}, 64'd0);
    chk("rst_cnt", commit_cnt, 64'd0);
    chk("rst_halt", {63'd0, dt_halt}, 64'd0);
    #2 rst = 1'b0;
    @(negedge clk);

    // Single commit, two-cycle latency
    push_rec(32'h8000_0000, 1'b1, 5'd5, 32'h0000_1234, 1'b0, 1'b0);
    idle();
    chk("lat_early", {63'd0, dt_valid}, 64'd0);
    @(negedge clk);
    chk("single_valid", {63'd0, dt_valid}, 64'd1);
    chk("single_pc", {32'd0, dt_pc}, 64'h8000_0000);
    chk("single_reg5", {32'd0, dt_rf[5*XLEN +: XLEN]}, 64'h1234);
    chk("single_cnt", commit_cnt, 64'd1);

    // x0 write is dropped
    push_rec(32'h8000_0004, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    idle();
    @(negedge clk);
    chk("x0_reg0", {32'd0, dt_rf[0 +: XLEN]}, 64'd0);
    chk("x0_cnt", commit_cnt, 64'd2);

    // Skip record (wen=0) then a normal write to the same register
    push_rec(32'h8000_0008, 1'b0, 5'd3, 32'h0000_DEAD, 1'b1, 1'b0);
    push_rec(32'h8000_000C, 1'b1, 5'd3, 32'h0000_BEEF, 1'b0, 1'b0);
    idle();
    chk("skip_on", {63'd0, dt_skip}, 64'd1);
    chk("skip_pc", {32'd0, dt_pc}, 64'h8000_0008);
    chk("skip_nowen", {32'd0, dt_rf[3*XLEN +: XLEN]}, 64'd0);
    @(negedge clk);
    chk("skip_off", {63'd0, dt_skip}, 64'd0);
    chk("skip_reg3", {32'd0, dt_rf[3*XLEN +: XLEN]}, 64'hBEEF);

    // Back-to-back pushes, then a DEPTH+1 burst
    for (int i = 0; i < 4; i++)
      push_rec(32'h8000_0100 + 32'(4*i), 1'b1, 5'(i+1), 32'h100 + 32'(i), 1'b0, 1'b0);
    for (int i = 0; i < DEPTH + 1; i++)
      push_rec(32'h8000_0200 + 32'(4*i), 1'b1, 5'(10+i), 32'h200 + 32'(i), 1'b0, 1'b0);
    idle();
    repeat (4) @(negedge clk);
    chk("burst_cnt", commit_cnt, 64'd13);
    chk("burst_last", {32'd0, dt_pc}, 64'h8000_0210);

    // Reset in the middle of a stream; record at release is discarded
    push_rec(32'h8000_0300, 1'b1, 5'd20, 32'h300, 1'b0, 1'b0);
    push_rec(32'h8000_0304, 1'b1, 5'd21, 32'h301, 1'b0, 1'b0);
    set_rec(32'h8000_0308, 1'b1, 5'd22, 32'h302, 1'b0, 1'b0);
    #2 rst = 1'b1;
    idle();
    @(negedge clk);
    chk("mid_valid", {63'd0, dt_valid}, 64'd0);
    chk("mid_cnt", commit_cnt, 64'd0);
    chk("mid_rf", (dt_rf == '0) ? 64'd1 : 64'd0, 64'd1);
    #2 rst = 1'b0;
    set_rec(32'h8000_0400, 1'b1, 5'd8, 32'h400, 1'b0, 1'b0);
    @(negedge clk);
    chk("rel_ready", {63'd0, wb.in_ready}, 64'd1);
    idle();
    repeat (3) @(negedge clk);
    chk("rel_discard", commit_cnt, 64'd0);

    // Halt on ebreak, later records frozen
    set_rec(32'h8000_0010, 1'b1, 5'd7, 32'h77, 1'b0, 1'b1);
    @(negedge clk);
    set_rec(32'h8000_0014, 1'b1, 5'd8, 32'h88, 1'b0, 1'b0);
    @(negedge clk);
    chk("halt_flag", {63'd0, dt_halt}, 64'd1);
    chk("halt_valid", {63'd0, dt_valid}, 64'd1);
    chk("halt_pc", {32'd0, dt_pc}, 64'h8000_0010);
    chk("halt_ready", {63'd0, wb.in_ready}, 64'd0);
    chk("halt_reg7", {32'd0, dt_rf[7*XLEN +: XLEN]}, 64'h77);
    set_rec(32'h8000_0018, 1'b1, 5'd9, 32'h99, 1'b0, 1'b0);
    @(negedge clk);
    idle();
    repeat (5) @(negedge clk);
    chk("halt_cnt", commit_cnt, 64'd1);
    chk("halt_frozen", {63'd0, dt_valid}, 64'd0);
    chk("halt_reg8", {32'd0, dt_rf[8*XLEN +: XLEN]}, 64'd0);

    // Reset with a frozen entry queued; it must not reappear
    #2 rst = 1'b1;
    @(negedge clk);
    chk("hrst_halt", {63'd0, dt_halt}, 64'd0);
    chk("hrst_pc", {32'd0, dt_pc}, 64'd0);
    #2 rst = 1'b0;
    @(negedge clk);
    push_rec(32'h8000_0500, 1'b1, 5'd9, 32'h999, 1'b0, 1'b0);
    idle();
    @(negedge clk);
    chk("post_valid", {63'd0, dt_valid}, 64'd1);
    chk("post_pc", {32'd0, dt_pc}, 64'h8000_0500);
    chk("post_cnt", commit_cnt, 64'd1);
    chk("post_reg9", {32'd0, dt_rf[9*XLEN +: XLEN]}, 64'h999);
    repeat (3) @(negedge clk);

    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/difftest_commit_queue.md
DIFFTEST_COMMIT_QUEUE -- requirements
Module: difftest_commit_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4: commit FIFO entries; power of two, at least 2.
REQ-002 SHALL have parameter XLEN, default 32: data and PC width.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst, input, 1: reset; asynchronous, active-high.
REQ-005 SHALL have port in_valid, input, 1: WB stage presents a retiring instruction.
REQ-006 SHALL have port in_ready, output, 1: queue accepts the record.
REQ-007 SHALL have port in_pc, input, XLEN: PC of the retiring instruction.
REQ-008 SHALL have port in_inst, input, 32: instruction word.
REQ-009 SHALL have port in_wen, input, 1: GPR write enable.
REQ-010 SHALL have port in_rd, input, 5: destination register index.
REQ-011 SHALL have port in_wdata, input, XLEN: GPR write data.
REQ-012 SHALL have port in_skip, input, 1: MMIO access; the reference model is to copy state rather than compare.
REQ-013 SHALL have port in_ebreak, input, 1: simulation-halt instruction.
REQ-014 SHALL have port dt_valid, output, 1: one-cycle strobe; snapshot ready for the difftest stage.
REQ-015 SHALL have port dt_pc, output, XLEN: PC of the snapshotted commit.
REQ-016 SHALL have port dt_skip, output, 1: skip flag of the snapshotted commit.
REQ-017 SHALL have port dt_rf, output, 32*XLEN: shadow GPRs after the commit; reg i occupies bits [i*XLEN +: XLEN].
REQ-018 SHALL have port dt_halt, output, 1: sticky halt flag.
REQ-019 SHALL have port commit_cnt, output, 64: number of drained commits.

Function
REQ-020 SHALL assert in_ready exactly when the FIFO is not full and dt_halt is 0.
REQ-021 SHALL push a record {pc, inst, wen, rd, wdata, skip, ebreak} when in_valid and in_ready are both 1.
REQ-022 SHALL pop the head record in any cycle where the FIFO is non-empty and dt_halt is 0; drain rate is one record per cycle.
REQ-023 SHALL complete a simultaneous push and pop in the same cycle; occupancy stays unchanged.
REQ-024 SHALL wrap read and write pointers modulo DEPTH; full and empty are distinguished by an extra pointer bit.
REQ-025 SHALL, on pop, write wdata into shadow register rd if wen=1 and rd!=0; shadow x0 always reads 0.
REQ-026 SHALL, in the cycle after a pop, drive dt_valid=1 with dt_pc, dt_skip and dt_rf reflecting that record's effect; latency from push into an empty FIFO to dt_valid is 2 cycles.
REQ-027 SHALL hold dt_pc, dt_skip and dt_rf stable when dt_valid=0.
REQ-028 SHALL increment commit_cnt by 1 per pop and wrap at 2^64.
REQ-029 SHALL set dt_halt in the cycle after popping a record with ebreak=1, concurrent with that record's dt_valid; once set, no further push or pop occurs and remaining entries are frozen.
REQ-030 SHALL make a record with in_wen=0 update only dt_pc and the counter.

Reset
REQ-031 SHALL, on rst=1 at any time including mid-drain, immediately empty the FIFO and clear all shadow registers, dt_pc, commit_cnt, dt_valid, dt_skip and dt_halt to 0; in_ready is 0 while rst=1 and is 1 from the first edge after release.
REQ-032 SHALL discard any record present on the first edge after rst deasserts only if in_ready was 0 in that cycle.

Verification
REQ-033 Single commit: push pc=0x80000000, wen=1, rd=5, wdata=0x1234 into an empty queue -> dt_valid 2 cycles later, dt_pc=0x80000000, reg5=0x1234, commit_cnt=1.
REQ-034 x0 write: push rd=0, wen=1, wdata=0xFFFFFFFF -> reg0 reads 0 and commit_cnt increments.
REQ-035 Back-to-back and full: push 4 records while draining, then burst DEPTH+1 records -> order is preserved, in_ready is never low when occupancy is below DEPTH, and there is no loss or duplication.
REQ-036 Halt: push an ebreak at pc=0x80000010 followed by 2 more records -> dt_halt=1 with dt_pc=0x80000010, later records are never emitted, and in_ready=0.
REQ-037 Reset mid-operation: assert rst with 3 entries queued -> dt_valid=0, commit_cnt=0, all dt_rf=0, and the FIFO is empty after release.
REQ-038 Skip: push in_skip=1 -> dt_skip=1 only on that record's dt_valid cycle.
